// File: rtl/alu_share_pkg.sv
// Shared types and default widths for the two-requester ALU sequencer.
package alu_share_pkg;

    localparam int unsigned DefaultDataW = 16;
    localparam int unsigned DefaultOpW   = 4;

    typedef enum logic [3:0] {
        AluAdd = 4'b0000,
        AluSub = 4'b0001,
        AluAnd = 4'b0011,
        AluOr  = 4'b0100,
        AluSlt = 4'b0110,
        AluBeq = 4'b0111
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/alu_share_rr_arb.sv
// Two-way round-robin arbiter; combinational, the last-grant pointer lives in the parent.
module alu_share_rr_arb (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            // On a tie the requester that did not win last time goes first.
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two requesters: round-robin accept, one execute cycle, held response.
// Optional grant/conflict counters are built when ALU_SHARE_CTRL_PERF_EN is defined.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW,
    parameter int unsigned OP_W   = DefaultOpW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic              busy
`ifdef ALU_SHARE_CTRL_PERF_EN
    ,
    output logic [15:0]       grant0_cnt,
    output logic [15:0]       grant1_cnt,
    output logic [15:0]       conflict_cnt
`endif
);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              gid_q, gid_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              zero_q, zero_d, err_q, err_d;

    logic [1:0]        grant;
    logic [DATA_W-1:0] alu_data;
    logic              alu_zero, alu_err;

    alu_share_rr_arb u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_comb begin
        alu_data = '0;
        alu_zero = 1'b0;
        alu_err  = 1'b0;
        case (op_q)
            AluAdd:  alu_data = a_q + b_q;
            AluSub:  alu_data = a_q - b_q;
            AluAnd:  alu_data = a_q & b_q;
            AluOr:   alu_data = a_q | b_q;
            AluSlt:  alu_data = DATA_W'(a_q < b_q);
            AluBeq:  alu_zero = (a_q == b_q);
            default: alu_err  = 1'b1;
        endcase
        if (!alu_err && (op_q != AluBeq)) begin
            alu_zero = (alu_data == '0);
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gid_d        = gid_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        data_d       = data_q;
        zero_d       = zero_q;
        err_d        = err_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (state_q)
            StIdle: begin
                if (grant != 2'b00) begin
                    req0_ready   = grant[0];
                    req1_ready   = grant[1];
                    gid_d        = grant[1];
                    last_grant_d = grant[1];
                    op_d         = grant[1] ? req1_op : req0_op;
                    a_d          = grant[1] ? req1_a : req0_a;
                    b_d          = grant[1] ? req1_b : req0_b;
                    state_d      = StExec;
                end
            end
            StExec: begin
                data_d  = alu_data;
                zero_d  = alu_zero;
                err_d   = alu_err;
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Nothing is accepted in the reset cycle.
        if (rst) begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            gid_q        <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            data_q       <= '0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gid_q        <= gid_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            data_q       <= data_d;
            zero_q       <= zero_d;
            err_q        <= err_d;
        end
    end

    assign rsp0_valid = (state_q == StResp) && !gid_q;
    assign rsp1_valid = (state_q == StResp) && gid_q;
    assign rsp_data   = data_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;
    assign busy       = (state_q != StIdle);

`ifdef ALU_SHARE_CTRL_PERF_EN
    logic [15:0] grant0_cnt_q, grant1_cnt_q, conflict_cnt_q;
    logic        idle_conflict;

    assign idle_conflict = (state_q == StIdle) && req0_valid && req1_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            grant0_cnt_q   <= '0;
            grant1_cnt_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (req0_ready && (grant0_cnt_q != 16'hFFFF)) begin
                grant0_cnt_q <= grant0_cnt_q + 16'd1;
            end
            if (req1_ready && (grant1_cnt_q != 16'hFFFF)) begin
                grant1_cnt_q <= grant1_cnt_q + 16'd1;
            end
            if (idle_conflict && (conflict_cnt_q != 16'hFFFF)) begin
                conflict_cnt_q <= conflict_cnt_q + 16'd1;
            end
        end
    end

    assign grant0_cnt   = grant0_cnt_q;
    assign grant1_cnt   = grant1_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl against a behavioural arbitration/ALU model.
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_zero, rsp_err, busy;
`ifdef ALU_SHARE_CTRL_PERF_EN
    logic [15:0] grant0_cnt, grant1_cnt, conflict_cnt;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    int   model_last;

    always #5 clk = ~clk;

    alu_share_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .busy       (busy)
`ifdef ALU_SHARE_CTRL_PERF_EN
        ,
        .grant0_cnt   (grant0_cnt),
        .grant1_cnt   (grant1_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    // Reference ALU: returns {err, zero, data}.
    function automatic logic [17:0] alu_ref(logic [3:0] op, logic [15:0] a, logic [15:0] b);
        logic [15:0] d;
        logic        z, e;
        d = 16'h0; z = 1'b0; e = 1'b0;
        case (op)
            4'd0: d = a + b;
            4'd1: d = a - b;
            4'd3: d = a & b;
            4'd4: d = a | b;
            4'd6: d = (a < b) ? 16'd1 : 16'd0;
            4'd7: d = 16'd0;
            default: e = 1'b1;
        endcase
        if (op == 4'd7) z = (a == b);
        else if (!e) z = (d == 16'd0);
        return {e, z, d};
    endfunction

    // Round-robin model: ties go to whoever did not win last; every grant moves the pointer.
    function automatic int model_grant(logic v0, logic v1);
        int g;
        if (v0 && v1) g = (model_last == 1) ? 0 : 1;
        else g = v0 ? 0 : 1;
        model_last = g;
        return g;
    endfunction

    task automatic drive_idle();
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_op = 4'h0; req1_op = 4'h0;
        req0_a = 16'h0; req0_b = 16'h0; req1_a = 16'h0; req1_b = 16'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_last = 1;
    endtask

    // Present one request set in IDLE, report which ready rose and the response latency.
    task automatic run_txn(input logic v0, input logic v1,
                           input logic [3:0] op0, input logic [15:0] a0, input logic [15:0] b0,
                           input logic [3:0] op1, input logic [15:0] a1, input logic [15:0] b1,
                           output int gid, output int lat);
        gid = -1;
        lat = 0;
        @(negedge clk);
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        #1;
        if (req0_ready && !req1_ready) gid = 0;
        else if (req1_ready && !req0_ready) gid = 1;
        else if (req0_ready && req1_ready) gid = 2;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            #1;
            if (rsp0_valid || rsp1_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_tests++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, rsp_err, busy} !== 7'b0 ||
            rsp_data !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b%b vld=%b%b z=%b e=%b busy=%b data=%h, want all 0",
                     req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, rsp_err, busy,
                     rsp_data);
        end
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
        model_last = 1;
    endtask

    task automatic test_add();
        int gid, lat;
        run_txn(1'b1, 1'b0, 4'd0, 16'h0003, 16'h0004, 4'd0, 16'h0, 16'h0, gid, lat);
        void'(model_grant(1'b1, 1'b0));
        n_tests++;
        if (gid !== 0 || lat !== 2) begin
            n_fail++;
            $display("FAIL add_handshake: grant=%0d latency=%0d, want grant=0 latency=2", gid, lat);
        end
        n_tests++;
        if ({rsp0_valid, rsp1_valid, rsp_err, rsp_zero, rsp_data} !== {4'b1000, 16'h0007}) begin
            n_fail++;
            $display("FAIL add_result: vld=%b%b e=%b z=%b data=%h, want vld=10 e=0 z=0 data=0007",
                     rsp0_valid, rsp1_valid, rsp_err, rsp_zero, rsp_data);
        end
        finish_rsp();
        n_tests++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_release: busy=%b rsp0_valid=%b, want 0 0", busy, rsp0_valid);
        end
    endtask

    task automatic test_stall();
        int gid, lat;
        run_txn(1'b0, 1'b1, 4'd0, 16'h0, 16'h0, 4'd1, 16'h0005, 16'h0005, gid, lat);
        void'(model_grant(1'b0, 1'b1));
        n_tests++;
        if (gid !== 1 || lat !== 2 ||
            {rsp0_valid, rsp1_valid, rsp_err, rsp_zero, rsp_data} !== {4'b0101, 16'h0000}) begin
            n_fail++;
            $display("FAIL sub_result: grant=%0d lat=%0d vld=%b%b e=%b z=%b data=%h, want 1 2 01 0 1 0000",
                     gid, lat, rsp0_valid, rsp1_valid, rsp_err, rsp_zero, rsp_data);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req0_valid = 1'b1; req1_valid = 1'b1;
            #1;
            n_tests++;
            if ({rsp0_valid, rsp1_valid, rsp_err, rsp_zero, busy, req0_ready, req1_ready}
                    !== 7'b0101100 || rsp_data !== 16'h0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: vld=%b%b e=%b z=%b busy=%b rdy=%b%b data=%h, want 01 0 1 1 00 0000",
                         i, rsp0_valid, rsp1_valid, rsp_err, rsp_zero, busy, req0_ready,
                         req1_ready, rsp_data);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        finish_rsp();
    endtask

    task automatic test_alternate();
        int gid, lat, exp_g;
        logic [15:0] a, b;
        logic [17:0] exp;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            run_txn(1'b1, 1'b1, 4'd0, a, b, 4'd4, b, a, gid, lat);
            exp_g = model_grant(1'b1, 1'b1);
            exp = alu_ref(exp_g == 0 ? 4'd0 : 4'd4, exp_g == 0 ? a : b, exp_g == 0 ? b : a);
            n_tests++;
            if (gid !== exp_g || gid !== (i % 2) || lat !== 2 ||
                {rsp_err, rsp_zero, rsp_data} !== exp) begin
                n_fail++;
                $display("FAIL alternate[%0d]: grant=%0d lat=%0d ezd=%h, want grant=%0d lat=2 ezd=%h",
                         i, gid, lat, {rsp_err, rsp_zero, rsp_data}, exp_g, exp);
            end
            finish_rsp();
        end
    endtask

    task automatic test_corners();
        int gid, lat;
        logic [3:0]  ops [6] = '{4'd7, 4'd6, 4'd0, 4'd2, 4'd15, 4'd6};
        logic [15:0] as  [6] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h00FF, 16'h0000, 16'h0001};
        logic [15:0] bs  [6] = '{16'h1234, 16'h0001, 16'h0001, 16'h00FF, 16'h0000, 16'hFFFF};
        logic [17:0] want[6] = '{{2'b01, 16'h0000}, {2'b01, 16'h0000}, {2'b01, 16'h0000},
                                 {2'b10, 16'h0000}, {2'b10, 16'h0000}, {2'b00, 16'h0001}};
        for (int i = 0; i < 6; i++) begin
            run_txn(1'b1, 1'b0, ops[i], as[i], bs[i], 4'd0, 16'h0, 16'h0, gid, lat);
            void'(model_grant(1'b1, 1'b0));
            n_tests++;
            if (gid !== 0 || lat !== 2 || {rsp_err, rsp_zero, rsp_data} !== want[i] ||
                {rsp_err, rsp_zero, rsp_data} !== alu_ref(ops[i], as[i], bs[i])) begin
                n_fail++;
                $display("FAIL corner[%0d] op=%h: grant=%0d lat=%0d ezd=%h, want grant=0 lat=2 ezd=%h",
                         i, ops[i], gid, lat, {rsp_err, rsp_zero, rsp_data}, want[i]);
            end
            finish_rsp();
        end
    endtask

    task automatic test_random();
        int gid, lat, exp_g;
        logic v0, v1;
        logic [3:0]  op0, op1;
        logic [15:0] a0, b0, a1, b1;
        logic [17:0] exp;
        for (int i = 0; i < 40; i++) begin
            {v1, v0} = 2'($urandom_range(1, 3));
            op0 = 4'($urandom_range(0, 15));
            op1 = 4'($urandom_range(0, 7));
            a0 = 16'($urandom); b0 = ($urandom_range(0, 3) == 0) ? a0 : 16'($urandom);
            a1 = 16'($urandom); b1 = ($urandom_range(0, 3) == 0) ? a1 : 16'($urandom);
            run_txn(v0, v1, op0, a0, b0, op1, a1, b1, gid, lat);
            exp_g = model_grant(v0, v1);
            exp = (exp_g == 0) ? alu_ref(op0, a0, b0) : alu_ref(op1, a1, b1);
            n_tests++;
            if (gid !== exp_g || lat !== 2 ||
                {rsp0_valid, rsp1_valid} !== ((exp_g == 0) ? 2'b10 : 2'b01) ||
                {rsp_err, rsp_zero, rsp_data} !== exp) begin
                n_fail++;
                $display("FAIL random[%0d] v=%b%b: grant=%0d lat=%0d vld=%b%b ezd=%h, want grant=%0d lat=2 ezd=%h",
                         i, v0, v1, gid, lat, rsp0_valid, rsp1_valid,
                         {rsp_err, rsp_zero, rsp_data}, exp_g, exp);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            finish_rsp();
        end
    endtask

    task automatic test_reset_exec();
        int gid, lat;
        logic seen;
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 16'h0010; req0_b = 16'h0020;
        #1;
        n_tests++;
        if (req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstexec_accept: req0_ready=%b, want 1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_last = 1;
        seen = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstexec_idle: busy=%b vld=%b%b, want 0 00", busy, rsp0_valid, rsp1_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (rsp0_valid || rsp1_valid || busy) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rstexec_dropped: response or busy seen=%b, want 0", seen);
        end
        run_txn(1'b1, 1'b1, 4'd3, 16'hF0F0, 16'h3C3C, 4'd4, 16'h0, 16'h0, gid, lat);
        void'(model_grant(1'b1, 1'b1));
        n_tests++;
        if (gid !== 0 || lat !== 2 || {rsp_err, rsp_zero, rsp_data} !== {2'b00, 16'h3030}) begin
            n_fail++;
            $display("FAIL rstexec_lastgrant: grant=%0d lat=%0d ezd=%h, want grant=0 lat=2 ezd=03030",
                     gid, lat, {rsp_err, rsp_zero, rsp_data});
        end
        finish_rsp();
    endtask

`ifdef ALU_SHARE_CTRL_PERF_EN
    task automatic test_perf();
        int gid, lat;
        logic [1:0] pat [5] = '{2'b11, 2'b11, 2'b01, 2'b01, 2'b10};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_txn(pat[i][0], pat[i][1], 4'd0, 16'h1, 16'h1, 4'd1, 16'h2, 16'h1, gid, lat);
            void'(model_grant(pat[i][0], pat[i][1]));
            finish_rsp();
        end
        n_tests++;
        if (grant0_cnt !== 16'd3 || grant1_cnt !== 16'd2 || conflict_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL perf_counters: g0=%0d g1=%0d conflict=%0d, want 3 2 2",
                     grant0_cnt, grant1_cnt, conflict_cnt);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        drive_idle();
        model_last = 1;
        test_reset();
        test_add();
        test_stall();
        test_alternate();
        test_corners();
        test_random();
        test_reset_exec();
`ifdef ALU_SHARE_CTRL_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
